// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;
    localparam int         XLEN      = 32;
    localparam logic [6:0] M_FUNCT7  = 7'b0000001;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
    typedef enum logic [1:0] {IDLE, CALC, FIN} muldiv_state_t;
endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: operand magnitude extraction and final sign correction/result selection.
module muldiv_signfix
    import muldiv_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    output logic              a_neg,
    output logic              b_neg,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    input  logic [2:0]        funct3_q,
    input  logic              sa_q,
    input  logic              sb_q,
    input  logic [2*XLEN-1:0] acc,
    output logic [XLEN-1:0]   fixed
);
    logic              a_signed, b_signed;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;
    always_comb begin
        a_signed = funct3 == F3_MULH || funct3 == F3_MULHSU || funct3 == F3_DIV || funct3 == F3_REM;
        b_signed = funct3 == F3_MULH || funct3 == F3_DIV || funct3 == F3_REM;
        a_neg    = a_signed && src_a[XLEN-1];
        b_neg    = b_signed && src_b[XLEN-1];
        mag_a    = a_neg ? -src_a : src_a;
        mag_b    = b_neg ? -src_b : src_b;
        prod     = (sa_q ^ sb_q) ? -acc : acc;
        quot     = (sa_q ^ sb_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        // remainder follows the dividend's sign
        rem      = sa_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fixed    = funct3_q[2] ? (funct3_q[1] ? rem : quot)
                               : (funct3_q == F3_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit with pipeline stall and flush abort.
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Result
);
    muldiv_state_t     state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step, mul_step, div_step;
    logic [XLEN-1:0]   mcand_q, mcand_d, result_q, result_d;
    logic [XLEN-1:0]   mag_a, mag_b, fixed, special_res;
    logic [2:0]        f3_q, f3_d;
    logic              sa_q, sa_d, sb_q, sb_d, a_neg, b_neg;
    logic              accept, special, last;
    logic [XLEN:0]     mul_sum, div_diff;

    muldiv_signfix u_signfix (
        .funct3(Funct3), .src_a(SrcA), .src_b(SrcB),
        .a_neg(a_neg), .b_neg(b_neg), .mag_a(mag_a), .mag_b(mag_b),
        .funct3_q(f3_q), .sa_q(sa_q), .sb_q(sb_q), .acc(acc_step), .fixed(fixed)
    );

    assign accept      = state_q == IDLE && start && !flush;
    assign special     = Funct3[2] && (SrcB == '0 || (!Funct3[0] && SrcA == 32'h8000_0000 && SrcB == '1));
    assign special_res = SrcB == '0 ? (Funct3[1] ? SrcA : '1) : (Funct3[1] ? '0 : 32'h8000_0000);
    assign last        = cnt_q == 6'd31;
    // acc holds {product} for multiply and {rem,quot} for divide
    assign mul_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, acc_q[0] ? mcand_q : '0};
    assign mul_step    = {mul_sum, acc_q[XLEN-1:1]};
    assign div_diff    = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mcand_q};
    assign div_step    = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                        : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign acc_step    = f3_q[2] ? div_step : mul_step;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = accept ? (special ? FIN : CALC) : IDLE;
            CALC:    state_d = flush ? IDLE : (last ? FIN : CALC);
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = state_q != IDLE;
        done   = state_q == FIN && !flush;
        stall  = accept || state_q == CALC;
        Result = result_q;
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        f3_d     = f3_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        result_d = result_q;
        if (accept) begin
            f3_d     = Funct3;
            sa_d     = a_neg;
            sb_d     = b_neg;
            acc_d    = {{XLEN{1'b0}}, mag_a};
            mcand_d  = mag_b;
            cnt_d    = '0;
            result_d = special ? special_res : result_q;
        end else if (state_q == CALC && !flush) begin
            cnt_d    = cnt_q + 6'd1;
            acc_d    = acc_step;
            result_d = last ? fixed : result_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            f3_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            f3_q     <= f3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            result_q <= result_d;
        end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vector and corner-sequence bench for muldiv_sequencer.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;
    logic        clk = 0, reset_n = 0, start = 0, flush = 0;
    logic [2:0]  Funct3 = '0;
    logic [31:0] SrcA = '0, SrcB = '0;
    logic        stall, busy, done;
    logic [31:0] Result;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .stall(stall), .busy(busy), .done(done), .Result(Result)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int stalls, output int lat);
        @(negedge clk);
        Funct3 = f3; SrcA = a; SrcB = b; start = 1;
        stalls = 0; lat = -1; res = 'x;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (stall) stalls++;
            if (done) begin
                lat = c;
                res = Result;
                break;
            end
            @(negedge clk);
        end
        start = 0;
    endtask

    initial begin
        logic [31:0] res, prev;
        int          stalls, lat, ndone;
        vecs[0]  = '{F3_DIV,    32'd5,          32'd0,          32'hFFFFFFFF, 1};
        vecs[1]  = '{F3_REMU,   32'd5,          32'd0,          32'd5,        1};
        vecs[2]  = '{F3_DIV,    32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1};
        vecs[3]  = '{F3_REM,    32'h80000000,   32'hFFFFFFFF,   32'd0,        1};
        vecs[4]  = '{F3_MUL,    32'd7,          32'hFFFFFFFD,   32'hFFFFFFEB, 33};
        vecs[5]  = '{F3_MULH,   32'h80000000,   32'h80000000,   32'h40000000, 33};
        vecs[6]  = '{F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE, 33};
        vecs[7]  = '{F3_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,        33};
        vecs[8]  = '{F3_DIVU,   32'd100,        32'd7,          32'd14,       33};
        vecs[9]  = '{F3_REMU,   32'd100,        32'd7,          32'd2,        33};
        vecs[10] = '{F3_DIV,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 33};
        vecs[11] = '{F3_REM,    32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF, 33};
        vecs[12] = '{F3_DIVU,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,        33};
        vecs[13] = '{F3_MULHSU, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF, 33};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_result", Result, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        reset_n = 1;

        foreach (vecs[i]) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, stalls, lat);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_done_cycle", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_stall_cycles", i), 32'(stalls), 32'(vecs[i].lat));
        end
        prev = vecs[13].exp;

        // flush mid-CALC: abort with no done and Result untouched
        @(negedge clk);
        Funct3 = F3_DIVU; SrcA = 32'd1000; SrcB = 32'd7; start = 1;
        repeat (11) @(negedge clk);
        flush = 1; start = 0;
        #1;
        chk("flush_busy_before", {31'd0, busy}, 32'd1);
        chk("flush_done_before", {31'd0, done}, 32'd0);
        @(negedge clk);
        #1;
        chk("flush_busy_after", {31'd0, busy}, 32'd0);
        chk("flush_done_after", {31'd0, done}, 32'd0);
        chk("flush_result_kept", Result, prev);
        flush = 0;
        run_op(F3_DIVU, 32'd9, 32'd3, res, stalls, lat);
        chk("post_flush_result", res, 32'd3);
        chk("post_flush_done_cycle", 32'(lat), 32'd33);
        chk("post_flush_stalls", 32'(stalls), 32'd33);

        // start held high: one done per accepted start, no overlap
        @(negedge clk);
        Funct3 = F3_DIV; SrcA = 32'd5; SrcB = 32'd0; start = 1;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (done) ndone++;
            @(negedge clk);
        end
        start = 0;
        chk("held_start_done_count", 32'(ndone), 32'd3);
        chk("held_start_result", Result, 32'hFFFFFFFF);

        // asynchronous reset during CALC
        @(negedge clk);
        Funct3 = F3_MUL; SrcA = 32'd3; SrcB = 32'd4; start = 1;
        repeat (5) @(negedge clk);
        #2;
        reset_n = 0; start = 0;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_stall", {31'd0, stall}, 32'd0);
        chk("midreset_result", Result, 32'd0);
        @(negedge clk);
        reset_n = 1;
        run_op(F3_MUL, 32'd3, 32'd4, res, stalls, lat);
        chk("after_reset_result", res, 32'd12);
        chk("after_reset_done_cycle", 32'(lat), 32'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
